traffic_intersection_ctrl: RTL

Parametrised two-road intersection controller: main/side signal heads, integrated phase timer, latched side-road and pedestrian demand, all-red clearance intervals and a night flashing mode. Successor to the single-direction `traffic_light_fsm` + external timer pair. It sits between the 1 Hz tick generator and the lamp drivers and owns all phase sequencing.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/phase_timer.sv | 27 ++
 rtl/traffic_intersection_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings, controller state codes and lamp decode for the
// intersection controller and its benches.
package traffic_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;
  localparam logic [1:0] OFF    = 2'b11;

  localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] S_ALLRED_A    = 3'd2;
  localparam logic [2:0] S_SIDE_GREEN  = 3'd3;
  localparam logic [2:0] S_SIDE_YELLOW = 3'd4;
  localparam logic [2:0] S_ALLRED_B    = 3'd5;
  localparam logic [2:0] S_FLASH       = 3'd6;

  typedef struct packed {
    logic [1:0] main_head;
    logic [1:0] side_head;
  } lights_t;

  function automatic lights_t decode_lights(input logic [2:0] st, input logic flash_on);
    lights_t l;
    unique case (st)
      S_MAIN_GREEN:  l = '{main_head: GREEN,  side_head: RED};
      S_MAIN_YELLOW: l = '{main_head: YELLOW, side_head: RED};
      S_SIDE_GREEN:  l = '{main_head: RED,    side_head: GREEN};
      S_SIDE_YELLOW: l = '{main_head: RED,    side_head: YELLOW};
      S_FLASH:       l = flash_on ? '{main_head: YELLOW, side_head: YELLOW}
                                  : '{main_head: OFF,    side_head: OFF};
      default:       l = '{main_head: RED,    side_head: RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; expire flags the tick that ends the current phase.
module phase_timer #(
  parameter int unsigned TIMER_W   = 8,
  parameter int unsigned RESET_VAL = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               tick_en,
  output logic               expire,
  output logic [TIMER_W-1:0] count
);

  assign expire = tick_en && (count == TIMER_W'(1));

  // Expiry always coincides with a reload, so the counter never reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= TIMER_W'(RESET_VAL);
    else if (load)
      count <= load_val;
    else if (tick_en && count != TIMER_W'(1))
      count <= count - TIMER_W'(1);
  end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: phase FSM, demand latches, walk lamp,
// night flashing and lamp decode around a shared phase timer.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TIMER_W          = 8,
  parameter int unsigned MAIN_GREEN_TICKS = 15,
  parameter int unsigned SIDE_GREEN_TICKS = 10,
  parameter int unsigned YELLOW_TICKS     = 3,
  parameter int unsigned ALLRED_TICKS     = 1,
  parameter int unsigned FLASH_TICKS      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic               side_req,
  input  logic               ped_req,
  input  logic               flash_mode,
  output logic [1:0]         main_light,
  output logic [1:0]         side_light,
  output logic               walk,
  output logic [TIMER_W-1:0] timer_val,
  output logic               timer_load,
  output logic [2:0]         phase
);

  logic [2:0]         state, next_state;
  logic               load, expire, enter_side;
  logic [TIMER_W-1:0] load_val;
  logic               side_dem, ped_dem, walk_q, flash_on;
  lights_t            lights;

  phase_timer #(
    .TIMER_W   (TIMER_W),
    .RESET_VAL (MAIN_GREEN_TICKS)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .tick_en  (tick_en),
    .expire   (expire),
    .count    (timer_val)
  );

  always_comb begin
    next_state = state;
    load       = expire;
    unique case (state)
      S_MAIN_GREEN:  if (expire) next_state = (side_dem || ped_dem) ? S_MAIN_YELLOW : S_MAIN_GREEN;
      S_MAIN_YELLOW: if (expire) next_state = S_ALLRED_A;
      S_ALLRED_A:    if (expire) next_state = flash_mode ? S_FLASH : S_SIDE_GREEN;
      S_SIDE_GREEN:  if (expire) next_state = S_SIDE_YELLOW;
      S_SIDE_YELLOW: if (expire) next_state = S_ALLRED_B;
      S_ALLRED_B:    if (expire) next_state = flash_mode ? S_FLASH : S_MAIN_GREEN;
      S_FLASH:       if (expire) next_state = flash_mode ? S_FLASH : S_ALLRED_B;
      default: begin
        next_state = S_ALLRED_B;
        load       = 1'b1;
      end
    endcase
  end

  always_comb begin
    unique case (next_state)
      S_MAIN_GREEN:                 load_val = TIMER_W'(MAIN_GREEN_TICKS);
      S_MAIN_YELLOW, S_SIDE_YELLOW: load_val = TIMER_W'(YELLOW_TICKS);
      S_SIDE_GREEN:                 load_val = TIMER_W'(SIDE_GREEN_TICKS);
      S_FLASH:                      load_val = TIMER_W'(FLASH_TICKS);
      default:                      load_val = TIMER_W'(ALLRED_TICKS);
    endcase
  end

  assign enter_side = load && (next_state == S_SIDE_GREEN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_MAIN_GREEN;
      timer_load <= 1'b0;
      side_dem   <= 1'b0;
      ped_dem    <= 1'b0;
      walk_q     <= 1'b0;
      flash_on   <= 1'b0;
    end else begin
      state      <= next_state;
      timer_load <= load;
      // A request in the clearing cycle must survive, so set has priority.
      side_dem   <= side_req || (side_dem && !enter_side);
      ped_dem    <= ped_req  || (ped_dem  && !enter_side);
      if (load) begin
        walk_q <= enter_side && ped_dem;
        if (next_state == S_FLASH)
          flash_on <= (state == S_FLASH) ? !flash_on : 1'b1;
        else
          flash_on <= 1'b0;
      end
    end
  end

  assign lights     = decode_lights(state, flash_on);
  assign main_light = lights.main_head;
  assign side_light = lights.side_head;
  assign walk       = walk_q && (state == S_SIDE_GREEN);
  assign phase      = state;

endmodule
